fwd_hazard_unit: RTL
====================

Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and hazard unit for the MIPS pipeline.
- Owns an internal shift-register of in-flight destination tags for FWD_DEPTH downstream stages (stage 1 = EXE, 2 = MEM, 3 = WB, ...).
- Selects the ALU operand sources for the instruction in ID.
- Detects load-use hazards and stalls ID, inserting a bubble.
- Supports flush and keeps a saturating stall-cycle counter.

Parameters:
- REG_AW, 5, register address width.
- FWD_DEPTH, 3, number of tracked downstream stages (>=2).
- LOAD_FWD_STAGE, 2, first stage index from which load data is forwardable (1..FWD_DEPTH).
- SEL_W, 2, selector width; must satisfy 2^SEL_W > FWD_DEPTH.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  REG_AW  source A register address.
- id_rt  in  REG_AW  source B register address.
- id_rs_used  in  1  instruction reads rs.
- id_rt_used  in  1  instruction reads rt as ALU operand B (0 for immediate forms).
- id_we  in  1  instruction writes a register.
- id_rd  in  REG_AW  destination address (already muxed by regDst upstream).
- id_is_load  in  1  instruction is a load.
- flush  in  1  kill all in-flight tags (branch taken/exception).
- sel_a  out  SEL_W  operand A source: 0 = register file, k = stage k.
- sel_b  out  SEL_W  operand B source, same encoding.
- stall  out  1  hold PC and IF/ID, inject bubble into EXE.
- stall_count  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Reset (rst_n low, asynchronous): all tags invalid, stall_count = 0. Hence sel_a = sel_b = 0 and stall = 0 while in reset and on the first cycle after.
- Each tag entry holds {valid, we, rd, is_load}.
- Shift on every posedge clk:
  - flush = 1: all entries cleared (flush overrides everything).
  - Otherwise: entry[1] <= (id_valid & !stall) ? ID tag : bubble (valid = 0), and entry[k] <= entry[k-1] for k = 2..FWD_DEPTH.
  - The shift never halts: a stall only replaces the EXE entry with a bubble.
- Match(k, src) = entry[k].valid & entry[k].we & entry[k].rd == src & src != 0. Register 0 is never forwarded and never stalls.
- sel_a: the smallest k with Match(k, id_rs) & id_rs_used, else 0. The nearest (youngest) producer wins. Combinational, same cycle. sel_b: same rule with id_rt / id_rt_used.
- stall = id_valid & !flush & some used source whose nearest match k has entry[k].is_load & k < LOAD_FWD_STAGE.
  - A farther load match hidden behind a nearer non-load match does not stall.
- While stall = 1, sel_a/sel_b still reflect the current matches (don't care to the datapath).
- Stall latency: a load followed immediately by a dependent instruction stalls LOAD_FWD_STAGE-1 cycles (1 cycle with the defaults). The consumer then receives sel = LOAD_FWD_STAGE.
- stall_count increments by 1 on each clock edge where stall = 1, and holds at 2^CNT_W-1 (no wrap).
- Flush and stall in the same cycle: flush wins. stall is forced to 0 and the counter does not increment.
- A reset mid-stall clears everything at once. No partial state survives.
- All outputs are combinational from entries and ID inputs, except stall_count, which is registered.

Test Plan:
- Back-to-back ALU ops: add r3 at ID, then sub reading r3 as rs next cycle -> sel_a = 1, stall = 0. One cycle later (r3 in stage 2) -> sel_a = 2.
- Load-use: lw r5, then add r6,r5,r5 -> stall = 1 for exactly 1 cycle, stall_count 0 -> 1, EXE entry is a bubble. Next cycle sel_a = sel_b = 2, stall = 0.
- Priority: r4 written at stage 1 and stage 3, ID reads r4 on rt with id_rt_used = 1 -> sel_b = 1. Same with id_rt_used = 0 -> sel_b = 0.
- r0 producer: lw r0 followed by a consumer reading r0 -> stall = 0, sel_a = 0.
- Flush: lw r7 in stage 1, consumer of r7 in ID, flush = 1 -> stall = 0, counter unchanged. Next cycle all sel = 0.
- Saturation: CNT_W = 2 with 5 consecutive load-use pairs -> stall_count reaches 3 and holds. Assert rst_n low mid-stall -> stall_count = 0 and stall = 0 immediately, without a clock edge.

Source files
------------

// File: rtl/fwd_hazard_unit_if.sv
// ID-stage interface of the forwarding/hazard unit: the instruction currently
// in ID, the flush request, and the operand-source / stall decisions.
//
// Handshake: the instruction in ID is accepted into EXE on a clock edge where
// id_valid = 1, stall = 0 and flush = 0. stall acts as an inverted ready. While
// stall = 1 the producer must hold the ID instruction unchanged. The unit
// inserts a bubble into EXE on that edge.
interface fwd_hazard_unit_if #(
    parameter int REG_AW = 5,
    parameter int SEL_W  = 2,
    parameter int CNT_W  = 16
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_rs_used;
    logic              id_rt_used;
    logic              id_we;
    logic [REG_AW-1:0] id_rd;
    logic              id_is_load;
    logic              flush;
    logic [SEL_W-1:0]  sel_a;
    logic [SEL_W-1:0]  sel_b;
    logic              stall;
    logic [CNT_W-1:0]  stall_count;

    // Pipeline control side: presents the ID instruction and consumes decisions.
    modport master (
        output id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
        output id_we, id_rd, id_is_load, flush,
        input  sel_a, sel_b, stall, stall_count
    );

    // Forwarding/hazard unit side.
    modport slave (
        input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
        input  id_we, id_rd, id_is_load, flush,
        output sel_a, sel_b, stall, stall_count
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit for the MIPS pipeline.
// Tracks destination tags of the FWD_DEPTH downstream stages (1 = EXE, 2 = MEM,
// 3 = WB, ...), picks the nearest producer for each ALU operand, stalls ID when
// the nearest producer is a load whose data is not yet forwardable, and counts
// stall cycles with a saturating counter.
// FWD_DEPTH must be >= 2, LOAD_FWD_STAGE in 1..FWD_DEPTH, 2**SEL_W > FWD_DEPTH.
module fwd_hazard_unit #(
    parameter int REG_AW         = 5,
    parameter int FWD_DEPTH      = 3,
    parameter int LOAD_FWD_STAGE = 2,
    parameter int SEL_W          = 2,
    parameter int CNT_W          = 16
) (
    input logic              clk,
    input logic              rst_n,
    fwd_hazard_unit_if.slave bus
);

    typedef struct packed {
        logic              valid;
        logic              we;
        logic [REG_AW-1:0] rd;
        logic              is_load;
    } tag_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // tags[k] describes the instruction currently in downstream stage k.
    tag_t tags [1:FWD_DEPTH];

    tag_t             id_tag;
    logic [SEL_W-1:0] sel_a_int;
    logic [SEL_W-1:0] sel_b_int;
    logic             hz_a;
    logic             hz_b;
    logic             found_a;
    logic             found_b;
    logic             stall_int;
    logic [CNT_W-1:0] stall_cnt;

    // A stage produces a forwardable value for src only if it writes src;
    // register 0 is hardwired and never forwarded.
    function automatic logic tag_match(input tag_t t, input logic [REG_AW-1:0] src);
        return t.valid && t.we && (t.rd == src) && (src != '0);
    endfunction

    // Tag of the instruction in ID, as it would enter EXE.
    always_comb begin
        id_tag         = '0;
        id_tag.valid   = 1'b1;
        id_tag.we      = bus.id_we;
        id_tag.rd      = bus.id_rd;
        id_tag.is_load = bus.id_is_load;
    end

    // Operand A: nearest (lowest k) matching producer wins; flag loads not yet forwardable.
    always_comb begin
        sel_a_int = '0;
        hz_a      = 1'b0;
        found_a   = 1'b0;
        for (int k = 1; k <= FWD_DEPTH; k++) begin
            if (!found_a && bus.id_rs_used && tag_match(tags[k], bus.id_rs)) begin
                found_a   = 1'b1;
                sel_a_int = SEL_W'(k);
                hz_a      = tags[k].is_load && (k < LOAD_FWD_STAGE);
            end
        end
    end

    // Operand B: same rule on rt; immediate forms clear id_rt_used.
    always_comb begin
        sel_b_int = '0;
        hz_b      = 1'b0;
        found_b   = 1'b0;
        for (int k = 1; k <= FWD_DEPTH; k++) begin
            if (!found_b && bus.id_rt_used && tag_match(tags[k], bus.id_rt)) begin
                found_b   = 1'b1;
                sel_b_int = SEL_W'(k);
                hz_b      = tags[k].is_load && (k < LOAD_FWD_STAGE);
            end
        end
    end

    // Stall only a real instruction; a flush kills the ID instruction anyway.
    always_comb begin
        stall_int = bus.id_valid && !bus.flush && (hz_a || hz_b);
    end

    // Tag pipeline: always shifts; a stall or idle ID feeds a bubble into EXE,
    // a flush wipes every in-flight tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k <= FWD_DEPTH; k++) begin
                tags[k] <= '0;
            end
        end else if (bus.flush) begin
            for (int k = 1; k <= FWD_DEPTH; k++) begin
                tags[k] <= '0;
            end
        end else begin
            tags[1] <= (bus.id_valid && !stall_int) ? id_tag : '0;
            for (int k = 2; k <= FWD_DEPTH; k++) begin
                tags[k] <= tags[k-1];
            end
        end
    end

    // Stall-cycle counter, saturating at all ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall_int && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    // Drive the interface outputs.
    always_comb begin
        bus.sel_a       = sel_a_int;
        bus.sel_b       = sel_b_int;
        bus.stall       = stall_int;
        bus.stall_count = stall_cnt;
    end

endmodule
